proposal_accept: RTL and testbench
==================================

PROPOSAL_ACCEPT -- requirements
Module: proposal_accept

Interface
REQ-001 Parameter N_VARS, default 16, width of the variable assignment vector.
REQ-002 Parameter SCORE_WIDTH, default 8, unsigned satisfied-clause count width.
REQ-003 Parameter ITER_WIDTH, default 16, iteration counter width.
REQ-004 in_clock  input  1  system clock; all state changes on its rising edge.
REQ-005 in_reset  input  1  reset, asynchronous, active-low.
REQ-006 in_start  input  1  single-cycle pulse; begins a search run.
REQ-007 in_init_assignment  input  N_VARS  starting assignment, sampled on accepted start.
REQ-008 in_init_score  input  SCORE_WIDTH  satisfied-clause count of the starting assignment.
REQ-009 in_total_clauses  input  SCORE_WIDTH  clause count meaning "all satisfied".
REQ-010 in_max_iter  input  ITER_WIDTH  iteration limit, sampled on accepted start; 0 = unlimited.
REQ-011 in_prop_valid / out_prop_ready  input/output  1 each  proposal handshake.
REQ-012 in_prop_assignment  input  N_VARS  proposed assignment from the sample block.
REQ-013 in_prop_score  input  SCORE_WIDTH  satisfied-clause count of the proposal.
REQ-014 in_p  input  1  accept decision from the probability block.
REQ-015 out_u / out_v  output  SCORE_WIDTH each  registered proposal score / current score, driving the probability block.
REQ-016 out_assignment  output  N_VARS  current (committed) assignment.
REQ-017 out_iter_count  output  ITER_WIDTH  completed decisions in this run.
REQ-018 out_accept  output  1  one-cycle pulse when a proposal is committed.
REQ-019 out_busy / out_done / out_solved  output  1 each  run active / run finished / finished with all clauses satisfied.

Function
REQ-020 FSM states IDLE, WAIT_PROP, DECIDE, DONE; all outputs registered except out_prop_ready = (state == WAIT_PROP).
REQ-021 IDLE or DONE with in_start=1: load out_assignment, out_v, iteration limit; clear out_iter_count, out_done, out_solved; next state WAIT_PROP, or DONE with out_solved=1 if in_init_score == in_total_clauses.
REQ-022 in_start while in WAIT_PROP or DECIDE is ignored.
REQ-023 WAIT_PROP: on in_prop_valid & out_prop_ready, latch in_prop_assignment and in_prop_score (to out_u); next state DECIDE; without valid, hold state.
REQ-024 DECIDE lasts exactly one cycle; in_p is sampled in that cycle (out_u, out_v stable since the previous edge).
REQ-025 DECIDE with in_p=1: out_assignment <= latched proposal, out_v <= out_u, out_accept=1 for the following cycle; in_p=0: current state unchanged, out_accept=0.
REQ-026 Every DECIDE increments out_iter_count by 1, saturating at all-ones.
REQ-027 DECIDE exit: new score == in_total_clauses -> DONE, out_solved=1; else limit nonzero and incremented count == limit -> DONE, out_solved=0; else WAIT_PROP.
REQ-028 Solved check takes priority over limit when both hold in the same DECIDE.
REQ-029 DONE: out_done=1, out_busy=0, outputs held until next in_start.
REQ-030 out_busy=1 in WAIT_PROP and DECIDE only.
REQ-031 Scores compared by unsigned equality only; scores above in_total_clauses are never treated as solved.
REQ-032 Proposal-to-commit latency: handshake edge + 1 cycle; one proposal consumed per 2 cycles maximum.

Reset
REQ-033 in_reset low asynchronously forces IDLE and zeroes out_assignment, out_u, out_v, out_iter_count, out_accept, out_busy, out_done, out_solved, limit register.
REQ-034 Reset asserted mid-run aborts the run; after release the block waits in IDLE for in_start.

Verification
REQ-035 Start, init_score=3, total=5, limit=4; proposal score 4 with in_p=1 -> out_accept pulse, out_v=4, out_iter_count=1, back in WAIT_PROP.
REQ-036 Proposal with in_p=0 -> out_assignment and out_v unchanged, out_iter_count increments, no out_accept.
REQ-037 limit=2, two rejected proposals -> DONE after second DECIDE, out_done=1, out_solved=0, out_iter_count=2.
REQ-038 Start with init_score == total=5 -> DONE next cycle, out_solved=1, out_iter_count=0, out_prop_ready never high.
REQ-039 Proposal score 5 (=total) accepted on the DECIDE reaching limit -> out_solved=1 (priority check).
REQ-040 in_reset low while in DECIDE -> all outputs zero immediately, IDLE; in_prop_valid held high after release -> out_prop_ready stays 0 until in_start.

Source files
------------

// File: rtl/proposal_accept.sv
// Proposal accept/commit stage of a local-search SAT solver: takes proposals from the sampler,
// asks the probability block via out_u/out_v and in_p, and commits or drops each one. One-cycle decide, ready only in WAIT_PROP.
module proposal_accept #(
  parameter int N_VARS      = 16,
  parameter int SCORE_WIDTH = 8,
  parameter int ITER_WIDTH  = 16
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_start,
  input  logic [N_VARS-1:0]      in_init_assignment,
  input  logic [SCORE_WIDTH-1:0] in_init_score,
  input  logic [SCORE_WIDTH-1:0] in_total_clauses,
  input  logic [ITER_WIDTH-1:0]  in_max_iter,
  input  logic                   in_prop_valid,
  output logic                   out_prop_ready,
  input  logic [N_VARS-1:0]      in_prop_assignment,
  input  logic [SCORE_WIDTH-1:0] in_prop_score,
  input  logic                   in_p,
  output logic [SCORE_WIDTH-1:0] out_u,
  output logic [SCORE_WIDTH-1:0] out_v,
  output logic [N_VARS-1:0]      out_assignment,
  output logic [ITER_WIDTH-1:0]  out_iter_count,
  output logic                   out_accept,
  output logic                   out_busy,
  output logic                   out_done,
  output logic                   out_solved
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_PROP, S_DECIDE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [N_VARS-1:0]      assign_q, assign_d;
  logic [N_VARS-1:0]      prop_q, prop_d;
  logic [SCORE_WIDTH-1:0] u_q, u_d;
  logic [SCORE_WIDTH-1:0] v_q, v_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic [ITER_WIDTH-1:0]  limit_q, limit_d;
  logic                   accept_q, accept_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   solved_q, solved_d;

  logic                   start_ok;
  logic                   init_solved;
  logic                   handshake;
  logic [ITER_WIDTH-1:0]  iter_inc;
  logic [SCORE_WIDTH-1:0] new_score;
  logic                   hit_solved;
  logic                   hit_limit;

  assign start_ok    = in_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign init_solved = (in_init_score == in_total_clauses);
  assign handshake   = in_prop_valid && (state_q == S_WAIT_PROP);
  assign iter_inc    = (iter_q == {ITER_WIDTH{1'b1}}) ? iter_q : iter_q + 1'b1;
  // Score after this decision: the proposal's if accepted, otherwise the current one.
  assign new_score   = in_p ? u_q : v_q;
  assign hit_solved  = (new_score == in_total_clauses);
  assign hit_limit   = (limit_q != '0) && (iter_inc == limit_q);

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = init_solved ? S_DONE : S_WAIT_PROP;
      S_WAIT_PROP:    if (handshake) state_d = S_DECIDE;
      S_DECIDE:       state_d = (hit_solved || hit_limit) ? S_DONE : S_WAIT_PROP;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    assign_d = assign_q;
    prop_d   = prop_q;
    u_d      = u_q;
    v_d      = v_q;
    iter_d   = iter_q;
    limit_d  = limit_q;
    accept_d = 1'b0;
    solved_d = solved_q;
    busy_d   = (state_d == S_WAIT_PROP) || (state_d == S_DECIDE);
    done_d   = (state_d == S_DONE);
    if (start_ok) begin
      assign_d = in_init_assignment;
      v_d      = in_init_score;
      limit_d  = in_max_iter;
      iter_d   = '0;
      solved_d = init_solved;
    end
    if (handshake) begin
      prop_d = in_prop_assignment;
      u_d    = in_prop_score;
    end
    if (state_q == S_DECIDE) begin
      iter_d   = iter_inc;
      solved_d = hit_solved;
      if (in_p) begin
        assign_d = prop_q;
        v_d      = u_q;
        accept_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      assign_q <= '0;
      prop_q   <= '0;
      u_q      <= '0;
      v_q      <= '0;
      iter_q   <= '0;
      limit_q  <= '0;
      accept_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      solved_q <= 1'b0;
    end else begin
      assign_q <= assign_d;
      prop_q   <= prop_d;
      u_q      <= u_d;
      v_q      <= v_d;
      iter_q   <= iter_d;
      limit_q  <= limit_d;
      accept_q <= accept_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      solved_q <= solved_d;
    end
  end

  assign out_prop_ready = (state_q == S_WAIT_PROP);
  assign out_assignment = assign_q;
  assign out_u          = u_q;
  assign out_v          = v_q;
  assign out_iter_count = iter_q;
  assign out_accept     = accept_q;
  assign out_busy       = busy_q;
  assign out_done       = done_q;
  assign out_solved     = solved_q;

endmodule

// File: tb/tb_proposal_accept.sv
// Directed bench for proposal_accept: per-cycle vector table plus a hand-written
// reset-during-decide sequence; total clauses fixed at 5.
module tb_proposal_accept;

  logic        in_clock = 1'b0;
  logic        in_reset;
  logic        in_start;
  logic [15:0] in_init_assignment;
  logic [7:0]  in_init_score;
  logic [7:0]  in_total_clauses;
  logic [15:0] in_max_iter;
  logic        in_prop_valid;
  logic        out_prop_ready;
  logic [15:0] in_prop_assignment;
  logic [7:0]  in_prop_score;
  logic        in_p;
  logic [7:0]  out_u;
  logic [7:0]  out_v;
  logic [15:0] out_assignment;
  logic [15:0] out_iter_count;
  logic        out_accept;
  logic        out_busy;
  logic        out_done;
  logic        out_solved;

  proposal_accept dut (
    .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start),
    .in_init_assignment(in_init_assignment), .in_init_score(in_init_score),
    .in_total_clauses(in_total_clauses), .in_max_iter(in_max_iter),
    .in_prop_valid(in_prop_valid), .out_prop_ready(out_prop_ready),
    .in_prop_assignment(in_prop_assignment), .in_prop_score(in_prop_score),
    .in_p(in_p), .out_u(out_u), .out_v(out_v), .out_assignment(out_assignment),
    .out_iter_count(out_iter_count), .out_accept(out_accept), .out_busy(out_busy),
    .out_done(out_done), .out_solved(out_solved)
  );

  always #5 in_clock = ~in_clock;

  typedef struct {
    logic        st;
    logic [15:0] ia;
    logic [7:0]  is;
    logic [15:0] mx;
    logic        pv;
    logic [15:0] pa;
    logic [7:0]  ps;
    logic        p;
    logic        rdy;
    logic        acc;
    logic [15:0] asg;
    logic [7:0]  u;
    logic [7:0]  v;
    logic [15:0] it;
    logic        bsy;
    logic        dn;
    logic        sol;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d got %0h want %0h", nm, step, act, exp);
    end
  endtask

  task automatic chk_zero(input int step);
    chk("rst_ready", step, 32'(out_prop_ready), 0);
    chk("rst_assign", step, 32'(out_assignment), 0);
    chk("rst_u", step, 32'(out_u), 0);
    chk("rst_v", step, 32'(out_v), 0);
    chk("rst_iter", step, 32'(out_iter_count), 0);
    chk("rst_accept", step, 32'(out_accept), 0);
    chk("rst_busy", step, 32'(out_busy), 0);
    chk("rst_done", step, 32'(out_done), 0);
    chk("rst_solved", step, 32'(out_solved), 0);
  endtask

  task automatic idle_inputs();
    in_start = 0; in_init_assignment = 0; in_init_score = 0; in_max_iter = 0;
    in_prop_valid = 0; in_prop_assignment = 0; in_prop_score = 0; in_p = 0;
  endtask

  initial begin
    in_total_clauses = 8'd5;
    idle_inputs();
    in_reset = 0;
    #12;
    chk_zero(-1);
    in_reset = 1;
    @(posedge in_clock); #1;
    chk_zero(-2);

    //        st ia      is  mx  pv pa       ps  p  rdy acc asg      u   v   it  bsy dn sol
    // accept then reject, ignored start, limit 4 reached on an accepted proposal
    vq.push_back('{1, 16'h00A5, 3, 4, 0, 16'h0000, 0, 0, 1, 0, 16'h00A5, 0, 3, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h1234, 4, 0, 0, 0, 16'h00A5, 4, 3, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h1234, 4, 4, 1, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'hBEEF, 2, 0, 0, 0, 16'h1234, 2, 4, 1, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1234, 2, 4, 2, 1, 0, 0});
    vq.push_back('{1, 16'hFFFF, 5, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h1234, 2, 4, 2, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0, 0, 16'h1234, 1, 4, 2, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1234, 1, 4, 3, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h0002, 3, 0, 0, 0, 16'h1234, 3, 4, 3, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0002, 3, 3, 4, 0, 1, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0002, 3, 3, 4, 0, 1, 0});
    // limit 2 with two rejections
    vq.push_back('{1, 16'h0F0F, 1, 2, 0, 16'h0000, 0, 0, 1, 0, 16'h0F0F, 3, 1, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'hAAAA, 4, 0, 0, 0, 16'h0F0F, 4, 1, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0F0F, 4, 1, 1, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h5555, 0, 0, 0, 0, 16'h0F0F, 0, 1, 1, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0F0F, 0, 1, 2, 0, 1, 0});
    // already solved at start; valid offered but never taken
    vq.push_back('{1, 16'h7777, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h7777, 0, 5, 0, 0, 1, 1});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h9999, 1, 0, 0, 0, 16'h7777, 0, 5, 0, 0, 1, 1});
    // solved and limit on the same decision: solved wins
    vq.push_back('{1, 16'h1111, 2, 1, 0, 16'h0000, 0, 0, 1, 0, 16'h1111, 0, 2, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'hFFFF, 5, 0, 0, 0, 16'h1111, 5, 2, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'hFFFF, 5, 5, 1, 0, 1, 1});
    // scores above total are not solved; unlimited run; rejected score-5 proposal
    vq.push_back('{1, 16'h2222, 6, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h2222, 5, 6, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h3333, 7, 0, 0, 0, 16'h2222, 7, 6, 0, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h3333, 7, 7, 1, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 1, 16'h4444, 5, 0, 0, 0, 16'h3333, 5, 7, 1, 1, 0, 0});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h3333, 5, 7, 2, 1, 0, 0});

    for (int i = 0; i < vq.size(); i++) begin
      in_start = vq[i].st; in_init_assignment = vq[i].ia; in_init_score = vq[i].is;
      in_max_iter = vq[i].mx; in_prop_valid = vq[i].pv; in_prop_assignment = vq[i].pa;
      in_prop_score = vq[i].ps; in_p = vq[i].p;
      @(posedge in_clock); #1;
      chk("ready", i, 32'(out_prop_ready), 32'(vq[i].rdy));
      chk("accept", i, 32'(out_accept), 32'(vq[i].acc));
      chk("assign", i, 32'(out_assignment), 32'(vq[i].asg));
      chk("u", i, 32'(out_u), 32'(vq[i].u));
      chk("v", i, 32'(out_v), 32'(vq[i].v));
      chk("iter", i, 32'(out_iter_count), 32'(vq[i].it));
      chk("busy", i, 32'(out_busy), 32'(vq[i].bsy));
      chk("done", i, 32'(out_done), 32'(vq[i].dn));
      chk("solved", i, 32'(out_solved), 32'(vq[i].sol));
    end

    // reset asserted while in DECIDE, then held valid must not be taken
    idle_inputs();
    in_prop_valid = 1; in_prop_assignment = 16'h5A5A; in_prop_score = 8'd2;
    @(posedge in_clock); #1;
    chk("pre_rst_decide_busy", 100, 32'(out_busy), 1);
    chk("pre_rst_decide_ready", 100, 32'(out_prop_ready), 0);
    in_p = 1;
    #2 in_reset = 0;
    #1 chk_zero(101);
    #3 in_reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge in_clock); #1;
      chk("post_rst_ready", 102 + c, 32'(out_prop_ready), 0);
      chk("post_rst_busy", 102 + c, 32'(out_busy), 0);
      chk("post_rst_iter", 102 + c, 32'(out_iter_count), 0);
    end
    in_p = 0; in_prop_valid = 0;
    in_start = 1; in_init_assignment = 16'hC3C3; in_init_score = 8'd0; in_max_iter = 0;
    @(posedge in_clock); #1;
    in_start = 0;
    chk("restart_ready", 110, 32'(out_prop_ready), 1);
    chk("restart_busy", 110, 32'(out_busy), 1);
    chk("restart_assign", 110, 32'(out_assignment), 32'h0000C3C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
